// File: rtl/uart_tx_arb_if.sv
// Requester/serializer handshake bundle for uart_tx_arb.
// The arbiter connects through modport master; the requesters and serializer use slave.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4,
  parameter int W_DAT = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*W_DAT-1:0] dat;
  logic [N_REQ-1:0]       ack;
  logic [N_REQ-1:0]       fin;
  logic [N_REQ-1:0]       err;
  logic                   busy;
  logic [W_DAT-1:0]       tx_dat;
  logic                   tx_snd;
  logic                   tx_fin;

  modport master (input req, dat, tx_fin, output ack, fin, err, busy, tx_dat, tx_snd);
  modport slave  (output req, dat, tx_fin, input ack, fin, err, busy, tx_dat, tx_snd);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting N_REQ requesters one frame at a time to a UART serializer.
// Optional WAIT timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int N_REQ  = 4,
  parameter int N_BYT  = 4,
  parameter int N_GAP  = 2,
  parameter int TO_CYC = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_arb_if.master  bus
);
  localparam int W_DAT = 8 * N_BYT;
  localparam int GI    = $clog2(N_REQ);
  localparam int GW    = (N_GAP > 0) ? $clog2(N_GAP + 1) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;

  state_e           state_q;
  logic [GI-1:0]    last_q, own_q, win, cand;
  logic [GW-1:0]    gap_q;
  logic [N_REQ-1:0] ack_q, fin_q, err_q;
  logic             busy_q, snd_q, to_hit;
  logic [W_DAT-1:0] dat_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_q;
  assign to_hit = (to_q == TW'(TO_CYC - 1));
`else
  // Never fires; TO_CYC only matters when the timeout is built in.
  assign to_hit = (TO_CYC < 0);
`endif

  // Scan from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    win  = last_q;
    cand = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GI'((int'(last_q) + k) % N_REQ);
      if (bus.req[cand]) win = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GI'(N_REQ - 1);
      own_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      fin_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      snd_q   <= 1'b0;
      dat_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      ack_q <= '0;
      fin_q <= '0;
      err_q <= '0;
      snd_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
            snd_q   <= 1'b1;
            own_q   <= win;
            last_q  <= win;
            ack_q   <= ONE << win;
            dat_q   <= bus.dat[W_DAT*win +: W_DAT];
`ifdef UART_ARB_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        WAIT: begin
          // A finish in the same cycle as the timeout counts as completion.
          if (bus.tx_fin || to_hit) begin
            if (bus.tx_fin) fin_q <= ONE << own_q;
            else            err_q <= ONE << own_q;
            gap_q <= '0;
            if (N_GAP == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end else begin
`ifdef UART_ARB_TIMEOUT_EN
            to_q <= to_q + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_q == GW'(N_GAP - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack    = ack_q;
  assign bus.fin    = fin_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.tx_snd = snd_q;
  assign bus.tx_dat = dat_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: expected grants are queued as requests are driven
// and checked whenever the arbiter issues tx_snd.
module tb_uart_tx_arb;
  localparam int N_REQ  = 4;
  localparam int N_BYT  = 4;
  localparam int N_GAP  = 2;
  localparam int TO_CYC = 100;
  localparam int W      = 8 * N_BYT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N_REQ), .W_DAT(W)) bus ();

  uart_tx_arb #(.N_REQ(N_REQ), .N_BYT(N_BYT), .N_GAP(N_GAP), .TO_CYC(TO_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic [W-1:0]     dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every send pulse must match the oldest queued grant.
  always @(negedge clk) begin
    if (rst_n && bus.tx_snd) begin
      if (exp_q.size() == 0) chk("snd_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("sb_ack", bus.ack, mon_e.ack);
        chk("sb_dat", bus.tx_dat, mon_e.dat);
      end
    end else if (rst_n && bus.ack != '0) begin
      chk("ack_without_snd", bus.ack, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int g);
    exp_t e;
    e.ack = N_REQ'(1) << g;
    e.dat = bus.dat[W*g +: W];
    exp_q.push_back(e);
  endtask

  task automatic wait_snd(input string tag, output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tx_snd) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk({tag, "_snd_timeout"}, 0, 1);
  endtask

  // Serializer finish pulse dly cycles after the current (negedge) cycle.
  task automatic finish_frame(input int dly, output int u);
    tick(dly);
    bus.tx_fin = 1'b1;
    u = cyc;
    tick(1);
    bus.tx_fin = 1'b0;
  endtask

  task automatic fin_tail(input string tag, input logic [N_REQ-1:0] f);
    @(negedge clk);
    chk({tag, "_fin"}, bus.fin, f);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy_gap"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_fin_pulse"}, bus.fin, 0);
    chk({tag, "_busy_gap2"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    bus.req    = '0;
    bus.tx_fin = 1'b0;
    rst_n      = 1'b0;
    tick(2);
    rst_n      = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int c, c0, u, e_c;
    bit ok;
    bus.req    = '0;
    bus.dat    = '0;
    bus.tx_fin = 1'b0;
    rst_n      = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_outs", {bus.busy, bus.tx_snd, bus.ack, bus.fin, bus.err, bus.tx_dat}, 0);

    // Single requester 2
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < N_REQ; i++) bus.dat[W*i +: W] = $urandom;
    bus.dat[W*2 +: W] = 32'hA5C3_0F11;
    bus.req = 4'b0100;
    c0 = cyc;
    expect_grant(2);
    wait_snd("single", c);
    chk("single_lat", c - c0, 1);
    chk("single_busy", bus.busy, 1);
    bus.req = '0;
    bus.dat[W*2 +: W] = 32'h0;
    @(negedge clk);
    chk("single_hold", bus.tx_dat, 32'hA5C3_0F11);
    tick(39);
    bus.tx_fin = 1'b1;
    tick(1);
    bus.tx_fin = 1'b0;
    fin_tail("single", 4'b0100);

    // Fairness with all requesters held
    do_reset();
    for (int i = 0; i < N_REQ; i++) bus.dat[W*i +: W] = {8'(i + 1), 24'hC0FFEE};
    bus.req = 4'b1111;
    expect_grant(0); expect_grant(1); expect_grant(2);
    expect_grant(3); expect_grant(0); expect_grant(1);
    u = 0;
    for (int k = 0; k < 6; k++) begin
      wait_snd("fair", c);
      if (k > 0) chk("fair_gap", c - u, N_GAP + 2);
      if (k == 5) bus.req = '0;
      finish_frame(10, u);
    end
    tick(N_GAP + 2);

    // Late request during WAIT of requester 1
    do_reset();
    bus.req = 4'b0010;
    expect_grant(1);
    wait_snd("late_a", c);
    bus.req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_noack", bus.ack, 0);
    end
    expect_grant(3);
    expect_grant(1);
    finish_frame(5, u);
    wait_snd("late_b", c);
    chk("late_b_gap", c - u, N_GAP + 2);
    bus.req = 4'b0010;
    finish_frame(5, u);
    wait_snd("late_c", c);
    bus.req = '0;
    finish_frame(5, u);
    tick(N_GAP + 2);

    // Spurious finish in IDLE and in GAP
    bus.tx_fin = 1'b1;
    tick(1);
    bus.tx_fin = 1'b0;
    @(negedge clk);
    chk("spur_idle_fin", bus.fin, 0);
    chk("spur_idle_busy", bus.busy, 0);
    bus.req = 4'b0001;
    expect_grant(0);
    wait_snd("spur", c);
    bus.req = '0;
    tick(3);
    bus.tx_fin = 1'b1;
    tick(1);
    @(negedge clk);
    chk("spur_fin", bus.fin, 4'b0001);
    tick(1);
    bus.tx_fin = 1'b0;
    @(negedge clk);
    chk("spur_gap_fin", bus.fin, 0);
    chk("spur_gap_busy", bus.busy, 1);
    @(negedge clk);
    chk("spur_gap_len", bus.busy, 0);

    // Reset in the middle of a frame
    bus.req = 4'b1000;
    expect_grant(3);
    wait_snd("rmf", c);
    bus.req = '0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmf_outs", {bus.busy, bus.tx_snd, bus.ack, bus.fin, bus.err, bus.tx_dat}, 0);
    bus.req = 4'b0011;
    expect_grant(0);
    wait_snd("rmf_first", c);
    bus.req = '0;
    finish_frame(4, u);
    fin_tail("rmf", 4'b0001);

    // Withheld finish: timeout abort, or indefinite wait without it
    bus.req = 4'b0010;
    expect_grant(1);
    wait_snd("to", c);
    bus.req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    e_c = -1;
    for (int i = 0; i < TO_CYC + 20; i++) begin
      @(negedge clk);
      if (bus.fin != '0) chk("to_nofin", bus.fin, 0);
      if (bus.err != '0) begin
        e_c = cyc;
        chk("to_err", bus.err, 4'b0010);
        break;
      end
    end
    chk("to_lat", e_c - c, TO_CYC);
    @(negedge clk);
    chk("to_err_pulse", bus.err, 0);
    chk("to_gap_busy", bus.busy, 1);
    tick(N_GAP + 2);
`else
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy || bus.err != '0 || bus.fin != '0) ok = 1'b0;
    end
    chk("hang_busy", ok, 1);
    finish_frame(1, u);
    fin_tail("hang", 4'b0010);
`endif

    tick(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (min 2).
REQ-002 SHALL have parameter N_BYT, default 4, bytes per frame; the frame data width is W_DAT = 8*N_BYT.
REQ-003 SHALL have parameter N_GAP, default 2, idle cycles inserted between frames (0 allowed).
REQ-004 SHALL have parameter TO_CYC, default 65535, timeout in clk cycles; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-005 SHALL have ports:
  - clk  in  1  system clock.
  - rst_n  in  1  reset; one clock, reset is synchronous and active-low.
  - req  in  N_REQ  per-requester send request, level.
  - dat  in  N_REQ*W_DAT  requester i data at dat[W_DAT*(i+1)-1 : W_DAT*i].
  - ack  out  N_REQ  one-cycle pulse: requester's data was latched.
  - fin  out  N_REQ  one-cycle pulse to the owning requester at frame completion.
  - err  out  N_REQ  one-cycle pulse to the owning requester on timeout abort.
  - busy  out  1  high in every state except IDLE.
  - tx_dat  out  W_DAT  frame data to the serializer.
  - tx_snd  out  1  one-cycle send pulse to the serializer.
  - tx_fin  in  1  one-cycle finish pulse from the serializer.

Function
REQ-006 SHALL implement the states IDLE, WAIT and GAP.
REQ-007 In IDLE with req != 0 at cycle t, the block SHALL pick winner g by round-robin and, at t+1:
  - assert tx_snd for one cycle;
  - drive tx_dat = dat slice g, captured at cycle t;
  - pulse ack[g];
  - enter WAIT.
REQ-008 Round-robin priority SHALL start at (last_grant+1) mod N_REQ; after reset last_grant = N_REQ-1, so requester 0 has top priority.
REQ-009 tx_dat SHALL remain stable from tx_snd until the next grant.
REQ-010 req SHALL be sampled only in IDLE; req changes in WAIT or GAP SHALL have no effect.
REQ-011 A requester SHALL hold req and dat until its ack; req still high after ack SHALL be treated as a new request.
REQ-012 In WAIT, tx_fin SHALL pulse fin[g] on the next cycle and move the block to GAP, or to IDLE when N_GAP = 0.
REQ-013 GAP SHALL last exactly N_GAP cycles, then return to IDLE.
REQ-014 The minimum distance between two tx_snd pulses SHALL be tx_fin-to-tx_snd = N_GAP+2 cycles.
REQ-015 tx_fin received in IDLE or GAP SHALL be ignored, with no fin pulse.
REQ-016 tx_fin arriving in the same cycle as the transition into WAIT SHALL NOT be counted.
REQ-017 At most one bit of ack, fin and err SHALL be high in any cycle; tx_snd and ack SHALL be asserted in the same cycle.
REQ-018 The internal grant index SHALL be $clog2(N_REQ) bits wide, and the GAP counter SHALL be wide enough to hold N_GAP.

Reset
REQ-019 While rst_n = 0 at a clk edge, the block SHALL set:
  - state = IDLE;
  - ack = 0, fin = 0, err = 0, busy = 0, tx_snd = 0, tx_dat = 0;
  - last_grant = N_REQ-1;
  - all counters = 0.
REQ-020 Reset mid-frame SHALL abandon ownership without issuing fin or err; the serializer SHALL share the same reset at integration.
REQ-021 The first grant after rst_n rises SHALL occur no earlier than 1 cycle after release.

Configuration
REQ-022 When macro UART_ARB_TIMEOUT_EN is defined, a counter SHALL run in WAIT, cleared on WAIT entry.
REQ-023 With UART_ARB_TIMEOUT_EN defined, reaching TO_CYC cycles without tx_fin SHALL pulse err[g] for one cycle and enter GAP; no fin is pulsed.
REQ-024 With UART_ARB_TIMEOUT_EN defined, tx_fin and the timeout in the same cycle SHALL resolve as a completion (fin, not err).
REQ-025 When UART_ARB_TIMEOUT_EN is undefined, the block SHALL omit the counter, tie err to 0, and wait in WAIT indefinitely.

Verification
REQ-026 Single requester: req=4'b0100, dat slice 2 = 32'hA5C3_0F11 -> next cycle tx_snd=1, ack=4'b0100, tx_dat=32'hA5C3_0F11, busy=1; tx_fin 40 cycles later -> fin=4'b0100 one cycle later, busy=0 after N_GAP=2 further cycles.
REQ-027 Fairness: req=4'b1111 held, re-asserted after each ack, tx_fin returned 10 cycles after each tx_snd -> grant order 0,1,2,3,0,1; each tx_snd exactly N_GAP+2 cycles after the previous tx_fin.
REQ-028 Late request: req[3] rises during WAIT of requester 1 -> no ack[3] until IDLE; then ack[3] before requester 1 is re-granted, even if req[1] is high.
REQ-029 Spurious finish: tx_fin pulsed in IDLE and again in GAP -> no fin pulse, state unchanged.
REQ-030 Reset mid-frame: rst_n low for 1 cycle during WAIT -> all outputs 0 the next cycle, no fin or err; req=4'b0011 afterwards -> requester 0 granted first.
REQ-031 With UART_ARB_TIMEOUT_EN and TO_CYC=100: grant requester 1 and withhold tx_fin -> err=4'b0010 exactly 100 cycles after WAIT entry; without the macro -> busy stays 1 with err=0 for 1000 cycles.
